mx8_arb: RTL and testbench

Round-robin arbiter and select sequencer for the 8:1 multiplexer `mx8`. It shares the mux among eight requesters, `a` through `h`. It grants one requester at a time and drives the mux select lines `s2..s0` so that the granted input appears on `y`. A grant is held while the requester keeps its request high, up to a bounded tenure, then passes fairly to the next requester.

---
 rtl/mx8_arb_pkg.sv | 13 +
 rtl/mx8_rr_pick.sv | 28 ++
 rtl/mx8_arb.sv | 106 ++++++++++
 tb/tb_mx8_arb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mx8_arb_pkg.sv
// Shared types and sizing for the mx8 round-robin arbiter.
// The state encoding is fixed so that it reads the same in waveforms and in the bench.
package mx8_arb_pkg;

  localparam int N_IN  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mx8_rr_pick.sv
// Combinational circular priority picker: finds the first set request
// at or after 'start', wrapping around from index 7 to index 0.
module mx8_rr_pick
  import mx8_arb_pkg::*;
(
  input  logic [N_IN-1:0]  req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] w_cand;

  // Candidate index wraps naturally in IDX_W bits; the first hit wins.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    w_cand = start;
    for (int i = 0; i < N_IN; i++) begin
      w_cand = start + IDX_W'(i);
      if (!found && req[w_cand]) begin
        idx   = w_cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mx8_arb.sv
// Round-robin arbiter and select sequencer for the mx8 8:1 mux.
// Grants one requester at a time, bounded to HOLD_MAX cycles while it keeps requesting.
module mx8_arb
  import mx8_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_IN-1:0] req,
  output logic [N_IN-1:0] gnt,
  output logic            s0,
  output logic            s1,
  output logic            s2,
  output logic            busy
);

  localparam logic [IDX_W-1:0] HOLD_LIM = IDX_W'(HOLD_MAX);

  state_t           r_state, w_next_state;
  logic [IDX_W-1:0] r_cur, w_next_cur;
  logic [IDX_W-1:0] r_ptr, w_next_ptr;
  logic [IDX_W-1:0] r_cnt, w_next_cnt;
  logic [IDX_W-1:0] r_sel, w_next_sel;
  logic [N_IN-1:0]  r_gnt, w_next_gnt;
  logic             r_busy, w_next_busy;

  logic             w_arb;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // From IDLE the search resumes at ptr; from GRANT it starts just after cur,
  // so cur itself is considered last and can be re-granted only if it is alone.
  assign w_arb   = (r_state == IDLE) ? (|req) : (!req[r_cur] || (r_cnt == HOLD_LIM));
  assign w_start = (r_state == IDLE) ? r_ptr : (r_cur + IDX_W'(1));

  mx8_rr_pick u_pick (
    .req   (req),
    .start (w_start),
    .idx   (w_idx),
    .found (w_found)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cur   <= w_next_cur;
      r_ptr   <= w_next_ptr;
      r_cnt   <= w_next_cnt;
      r_sel   <= w_next_sel;
      r_gnt   <= w_next_gnt;
      r_busy  <= w_next_busy;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cur   = r_cur;
    w_next_ptr   = r_ptr;
    w_next_cnt   = r_cnt;
    if (w_arb) begin
      if (w_found) begin
        w_next_state = GRANT;
        w_next_cur   = w_idx;
        w_next_cnt   = IDX_W'(1);
      end else begin
        w_next_state = IDLE;
        w_next_ptr   = r_cur + IDX_W'(1);
        w_next_cnt   = '0;
      end
    end else if (r_state == GRANT) begin
      w_next_cnt = r_cnt + IDX_W'(1);
    end
  end

  // Select lines keep their last value when the arbiter drops to IDLE.
  always_comb begin
    w_next_gnt  = r_gnt;
    w_next_sel  = r_sel;
    w_next_busy = r_busy;
    if (w_arb) begin
      if (w_found) begin
        w_next_gnt  = N_IN'(1) << w_idx;
        w_next_sel  = w_idx;
        w_next_busy = 1'b1;
      end else begin
        w_next_gnt  = '0;
        w_next_busy = 1'b0;
      end
    end
  end

  assign gnt          = r_gnt;
  assign {s2, s1, s0} = r_sel;
  assign busy         = r_busy;

endmodule

// File: tb/tb_mx8_arb.sv
// Self-checking bench for mx8_arb: directed scenarios with literal expectations
// plus randomized requests compared every cycle against a behavioural model.
module tb_mx8_arb;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       s0, s1, s2, busy;

  int testsRun = 0;
  int testsFailed = 0;

  // Behavioural model state: which index holds the grant and for how long.
  int mBusy = 0;
  int mCur = 0;
  int mPtr = 0;
  int mCnt = 0;
  int mSel = 0;

  mx8_arb #(.HOLD_MAX(HM)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt),
    .s0      (s0),
    .s1      (s1),
    .s2      (s2),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] v);
    @(negedge clk);
    req = v;
  endtask

  function automatic int pickFrom(input int startIdx, input logic [7:0] r);
    for (int k = 0; k < 8; k++) begin
      if (r[(startIdx + k) % 8]) return (startIdx + k) % 8;
    end
    return -1;
  endfunction

  function automatic int idxOf(input logic [7:0] g);
    for (int k = 0; k < 8; k++) begin
      if (g == (8'h01 << k)) return k;
    end
    return -1;
  endfunction

  // Reference model: arbitrate when idle with requests, or when the holder
  // releases or has used up its tenure; otherwise the tenure grows by one.
  always @(posedge clk or negedge reset_n) begin
    int w;
    if (!reset_n) begin
      mBusy = 0; mCur = 0; mPtr = 0; mCnt = 0; mSel = 0;
    end else if (mBusy == 0) begin
      w = pickFrom(mPtr, req);
      if (w >= 0) begin
        mBusy = 1; mCur = w; mCnt = 1; mSel = w;
      end
    end else if (!req[mCur] || mCnt == HM) begin
      w = pickFrom((mCur + 1) % 8, req);
      if (w >= 0) begin
        mCur = w; mCnt = 1; mSel = w;
      end else begin
        mBusy = 0; mPtr = (mCur + 1) % 8; mCnt = 0;
      end
    end else begin
      mCnt = mCnt + 1;
    end
  end

  // Every cycle, away from the active edge, the DUT must agree with the model.
  always @(negedge clk) begin
    checkOutput("modelGnt", gnt, mBusy ? (1 << mCur) : 0);
    checkOutput("modelBusy", busy, mBusy);
    checkOutput("modelSel", {s2, s1, s0}, mSel);
  end

  initial begin
    int prevIdx, runLen, runs, curIdx, waited;
    reset_n = 1'b0;
    req = 8'h00;
    #12;
    checkOutput("resetGnt", gnt, 8'h00);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetSel", {s2, s1, s0}, 0);

    @(negedge clk);
    reset_n = 1'b1;
    req = 8'h01;
    @(posedge clk); #1;
    checkOutput("firstGnt", gnt, 8'h01);
    checkOutput("firstBusy", busy, 1);
    checkOutput("firstSel", {s2, s1, s0}, 0);

    applyStimulus(8'h00);
    @(posedge clk); #1;
    checkOutput("dropGnt", gnt, 8'h00);
    checkOutput("dropBusy", busy, 0);
    checkOutput("dropSel", {s2, s1, s0}, 0);

    // ptr is now 1, so h wins first, then a and h alternate every HM cycles.
    applyStimulus(8'h81);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checkOutput("altGnt", gnt, (i >= 4 && i < 8) ? 8'h01 : 8'h80);
      checkOutput("altSel", {s2, s1, s0}, (i >= 4 && i < 8) ? 0 : 7);
      checkOutput("altBusy", busy, 1);
    end

    applyStimulus(8'h04);
    @(posedge clk); #1;
    checkOutput("handC", gnt, 8'h04);
    applyStimulus(8'h20);
    @(posedge clk); #1;
    checkOutput("handF", gnt, 8'h20);
    checkOutput("handFSel", {s2, s1, s0}, 5);
    checkOutput("handFBusy", busy, 1);

    applyStimulus(8'h10);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("soloGnt", gnt, 8'h10);
      checkOutput("soloBusy", busy, 1);
    end

    // All requesting: indices rotate upward, each full tenure exactly HM cycles.
    applyStimulus(8'hFF);
    prevIdx = -1; runLen = 0; runs = 0;
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      curIdx = idxOf(gnt);
      if (curIdx == prevIdx) begin
        runLen++;
      end else begin
        if (runs >= 2) begin
          checkOutput("ffRunLen", runLen, HM);
          checkOutput("ffNextIdx", curIdx, (prevIdx + 1) % 8);
        end
        runs++;
        prevIdx = curIdx;
        runLen = 1;
      end
    end

    applyStimulus(8'h40);
    waited = 0;
    while (gnt !== 8'h40 && waited < 16) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("reachG", gnt, 8'h40);
    checkOutput("reachGSel", {s2, s1, s0}, 6);

    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("asyncGnt", gnt, 8'h00);
    checkOutput("asyncBusy", busy, 0);
    checkOutput("asyncSel", {s2, s1, s0}, 0);
    #1 reset_n = 1'b1;
    req = 8'hC0;
    @(posedge clk); #1;
    checkOutput("restartGnt", gnt, 8'h40);
    checkOutput("restartSel", {s2, s1, s0}, 6);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0:       applyStimulus(8'h00);
          1:       applyStimulus(8'h01 << $urandom_range(0, 7));
          default: applyStimulus(8'($urandom));
        endcase
      end else begin
        @(negedge clk);
      end
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
